approx_mult_sequencer: RTL and testbench

APPROX_MULT_SEQUENCER -- requirements
Module: approx_mult_sequencer

---
 rtl/approx_mult_sequencer.sv | 98 +++++++++
 tb/tb_approx_mult_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_sequencer.sv
// Sequential shift-add multiplier that borrows an external (possibly approximate)
// adder for each accumulate step. One product every N cycles, valid/ready on both sides.
`timescale 1ns/1ps
module approx_mult_sequencer #(
  parameter int unsigned N      = 4,
  parameter int unsigned MASK_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  input  logic [MASK_W-1:0] mask,
  output logic [N-1:0]      add_a,
  output logic [N-1:0]      add_b,
  output logic [MASK_W-1:0] add_mask,
  input  logic [N-1:0]      add_sum,
  input  logic              add_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*N-1:0]    product,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(N) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t            state_q;
  logic [N-1:0]      m_q;
  logic [N-1:0]      acc_q;
  logic [N-1:0]      q_q;
  logic [MASK_W-1:0] mask_q;
  logic [CntW-1:0]   cnt_q;
  logic              accept;

  // Handshake: a finished product must be taken before a new pair can land.
  always_comb begin
    in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    accept   = in_valid & in_ready;
  end

  // Adder operands come straight from the registers so the mask is stable all of RUN.
  assign add_a    = acc_q;
  assign add_b    = m_q;
  assign add_mask = mask_q;
  assign product  = {acc_q, q_q};
  assign busy     = (state_q != StIdle);

  // Control FSM and datapath registers; out_valid is a registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      // Also covers DONE -> RUN back-to-back; out_valid drops on the same edge.
      state_q   <= StRun;
      m_q       <= a;
      acc_q     <= '0;
      q_q       <= b;
      mask_q    <= mask;
      cnt_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (q_q[0]) begin
            acc_q <= {add_cout, add_sum[N-1:1]};
            q_q   <= {add_sum[0], q_q[N-1:1]};
          end else begin
            // Multiplier bit is zero: pure shift, adder result is ignored.
            acc_q <= {1'b0, acc_q[N-1:1]};
            q_q   <= {acc_q[0], q_q[N-1:1]};
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(N - 1)) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mult_sequencer.sv
// Bench for approx_mult_sequencer with an exact adder attached: directed vectors,
// backpressure/back-to-back and reset corner cases, then a randomized full sweep.
`timescale 1ns/1ps
module tb_approx_mult_sequencer;

  localparam int unsigned N      = 4;
  localparam int unsigned MASK_W = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      a;
  logic [N-1:0]      b;
  logic [MASK_W-1:0] mask;
  logic [N-1:0]      add_a;
  logic [N-1:0]      add_b;
  logic [MASK_W-1:0] add_mask;
  logic [N-1:0]      add_sum;
  logic              add_cout;
  logic              out_valid;
  logic              out_ready;
  logic [2*N-1:0]    product;
  logic              busy;

  int checks = 0;
  int errors = 0;

  approx_mult_sequencer #(.N(N), .MASK_W(MASK_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .mask     (mask),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_mask (add_mask),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  // Exact adder model.
  logic [N:0] sum_full;
  assign sum_full = {1'b0, add_a} + {1'b0, add_b};
  assign add_sum  = sum_full[N-1:0];
  assign add_cout = sum_full[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present a pair from IDLE/DONE and step through the accept edge.
  task automatic accept_op(input logic [N-1:0] av, input logic [N-1:0] bv,
                           input logic [MASK_W-1:0] mv);
    in_valid = 1'b1;
    a = av;
    b = bv;
    mask = mv;
    #1;
    check("in_ready_at_accept", 16'(in_ready), 16'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Garbage on the operand bus must not disturb the running product.
    a = ~av;
    b = ~bv;
    mask = ~mv;
  endtask

  // Called #1 after the accept edge; counts edges until out_valid shows up.
  task automatic wait_done(input logic [N-1:0] av, input logic [MASK_W-1:0] mv,
                           input logic [2*N-1:0] exp, input string name);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      check({name, "_run_mask"}, 16'(add_mask), 16'(mv));
      check({name, "_run_addb"}, 16'(add_b), 16'(av));
      check({name, "_run_inready"}, 16'(in_ready), 16'd0);
      check({name, "_run_busy"}, 16'(busy), 16'd1);
      in_valid = 1'b1;  // must be ignored during RUN
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat++;
    end
    check({name, "_latency"}, 16'(lat), 16'(N));
    check({name, "_product"}, 16'(product), 16'(exp));
    check({name, "_done_busy"}, 16'(busy), 16'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    #1;
    check("drain_inready", 16'(in_ready), 16'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_outvalid", 16'(out_valid), 16'd0);
    check("drain_busy", 16'(busy), 16'd0);
  endtask

  typedef struct {
    logic [N-1:0]      a;
    logic [N-1:0]      b;
    logic [MASK_W-1:0] m;
    logic [2*N-1:0]    exp;
  } vec_t;

  vec_t vecs[8];
  logic [2*N-1:0] exp_q[$];
  logic [2*N-1:0] e;
  logic [2*N-1:0] held;
  int sent;
  int cyc;

  initial begin
    vecs[0] = '{a: 4'd15, b: 4'd15, m: 3'b000, exp: 8'hE1};
    vecs[1] = '{a: 4'd13, b: 4'd11, m: 3'b101, exp: 8'h8F};
    vecs[2] = '{a: 4'd0,  b: 4'd9,  m: 3'b000, exp: 8'h00};
    vecs[3] = '{a: 4'd7,  b: 4'd0,  m: 3'b010, exp: 8'h00};
    vecs[4] = '{a: 4'd1,  b: 4'd1,  m: 3'b111, exp: 8'h01};
    vecs[5] = '{a: 4'd15, b: 4'd1,  m: 3'b011, exp: 8'h0F};
    vecs[6] = '{a: 4'd8,  b: 4'd8,  m: 3'b100, exp: 8'h40};
    vecs[7] = '{a: 4'd5,  b: 4'd10, m: 3'b001, exp: 8'h32};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    mask = '0;
    #12;
    check("rst_outvalid", 16'(out_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_product", 16'(product), 16'd0);
    check("rst_adda", 16'(add_a), 16'd0);
    check("rst_addb", 16'(add_b), 16'd0);
    check("rst_addmask", 16'(add_mask), 16'd0);
    check("rst_inready", 16'(in_ready), 16'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      accept_op(vecs[i].a, vecs[i].b, vecs[i].m);
      wait_done(vecs[i].a, vecs[i].m, vecs[i].exp, $sformatf("vec%0d", i));
      drain();
    end

    // Backpressure in DONE, then back-to-back accept with no idle cycle.
    accept_op(4'd13, 4'd11, 3'b101);
    wait_done(4'd13, 3'b101, 8'h8F, "hold");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("hold_outvalid", 16'(out_valid), 16'd1);
      check("hold_product", 16'(product), 16'h8F);
      check("hold_inready", 16'(in_ready), 16'd0);
    end
    out_ready = 1'b1;
    accept_op(4'd3, 4'd5, 3'b010);
    out_ready = 1'b0;
    check("b2b_outvalid", 16'(out_valid), 16'd0);
    check("b2b_busy", 16'(busy), 16'd1);
    wait_done(4'd3, 3'b010, 8'h0F, "b2b");
    drain();

    // Asynchronous reset two iterations into a run.
    accept_op(4'd15, 4'd15, 3'b000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_outvalid", 16'(out_valid), 16'd0);
    check("midrst_product", 16'(product), 16'd0);
    check("midrst_busy", 16'(busy), 16'd0);
    check("midrst_addb", 16'(add_b), 16'd0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_inready", 16'(in_ready), 16'd1);
    @(posedge clk);
    #1;
    accept_op(4'd6, 4'd7, 3'b001);
    wait_done(4'd6, 3'b001, 8'd42, "postrst");
    drain();

    // Exhaustive sweep with random valid/ready; reference is a*b through an in-order queue.
    sent = 0;
    cyc = 0;
    while ((sent < 256 || exp_q.size() > 0) && cyc < 20000) begin
      if (sent < 256) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = sent[7:4];
        b = sent[3:0];
        mask = MASK_W'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sweep_unexpected_output", 16'(product), 16'hFFFF);
        end else begin
          held = exp_q.pop_front();
          check("sweep_product", 16'(product), 16'(held));
        end
      end
      if (in_valid && in_ready) begin
        e = {4'b0, a} * {4'b0, b};
        exp_q.push_back(e);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("sweep_sent", 16'(sent), 16'd256);
    check("sweep_drained", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
